// File: rtl/dtree_seq_classifier_pkg.sv
// Shared types and node-layout helpers for the sequential decision-tree classifier.
// Node word, MSB->LSB: {leaf, fidx, thresh, left, right, class}.
package dtree_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WALK = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int DEF_N_FEAT    = 9;
  localparam int DEF_FEAT_W    = 8;
  localparam int DEF_CLASS_W   = 2;
  localparam int DEF_N_NODES   = 31;
  localparam int DEF_MAX_DEPTH = 5;

  // Index width that stays at least one bit wide for degenerate sizes.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int node_w(input int n_feat, input int feat_w,
                                input int n_nodes, input int class_w);
    return 1 + idx_w(n_feat) + feat_w + 2 * idx_w(n_nodes) + class_w;
  endfunction

  function automatic int right_lsb(input int class_w);
    return class_w;
  endfunction

  function automatic int left_lsb(input int class_w, input int n_nodes);
    return class_w + idx_w(n_nodes);
  endfunction

  function automatic int thr_lsb(input int class_w, input int n_nodes);
    return class_w + 2 * idx_w(n_nodes);
  endfunction

  function automatic int fidx_lsb(input int class_w, input int n_nodes, input int feat_w);
    return thr_lsb(class_w, n_nodes) + feat_w;
  endfunction

  function automatic int leaf_bit(input int n_feat, input int feat_w,
                                  input int n_nodes, input int class_w);
    return node_w(n_feat, feat_w, n_nodes, class_w) - 1;
  endfunction

endpackage

// File: rtl/dtree_seq_classifier_if.sv
// Feature-in / class-out valid-ready channels plus the node-table config port.
interface dtree_seq_classifier_if
  import dtree_pkg::*;
#(
  parameter int N_FEAT  = DEF_N_FEAT,
  parameter int FEAT_W  = DEF_FEAT_W,
  parameter int CLASS_W = DEF_CLASS_W,
  parameter int N_NODES = DEF_N_NODES
);
  localparam int NODE_AW = idx_w(N_NODES);
  localparam int NODE_W  = node_w(N_FEAT, FEAT_W, N_NODES, CLASS_W);

  logic                     in_valid;
  logic                     in_ready;
  logic [N_FEAT*FEAT_W-1:0] in_x;
  logic                     out_valid;
  logic                     out_ready;
  logic [CLASS_W-1:0]       out_class;
  logic                     out_err;
  logic                     cfg_we;
  logic [NODE_AW-1:0]       cfg_addr;
  logic [NODE_W-1:0]        cfg_data;
  logic                     cfg_busy;

  modport master (
    output in_valid, in_x, out_ready, cfg_we, cfg_addr, cfg_data,
    input  in_ready, out_valid, out_class, out_err, cfg_busy
  );

  modport slave (
    input  in_valid, in_x, out_ready, cfg_we, cfg_addr, cfg_data,
    output in_ready, out_valid, out_class, out_err, cfg_busy
  );
endinterface

// File: rtl/dtree_seq_classifier_node_mem.sv
// Node table: N_NODES x NODE_W register file, async read, sync write,
// async reset of every entry to a class-0 leaf (leaf flag is the MSB).
module dtree_node_mem #(
  parameter int N_NODES = 31,
  parameter int NODE_W  = 25,
  parameter int AW      = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [NODE_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [NODE_W-1:0] rdata
);
  localparam logic [NODE_W-1:0] RST_NODE = {1'b1, {(NODE_W-1){1'b0}}};
  localparam logic [AW:0]       N_LIM    = (AW+1)'(N_NODES);

  logic [NODE_W-1:0] mem_q [N_NODES];
  logic [NODE_W-1:0] mem_d [N_NODES];

  always_comb begin
    mem_d = mem_q;
    if (we && ({1'b0, waddr} < N_LIM)) begin
      mem_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_NODES; i++) begin
        mem_q[i] <= RST_NODE;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Out-of-range addresses read as a harmless leaf; the walker never issues them.
  assign rdata = ({1'b0, raddr} < N_LIM) ? mem_q[raddr] : RST_NODE;
endmodule

// File: rtl/dtree_seq_classifier.sv
// Sequential decision-tree classifier: walks the programmable node table one level per clock.
// Optional feature macro: DTREE_STATS_EN adds saturating stat_done / stat_err counters.
module dtree_seq_classifier
  import dtree_pkg::*;
#(
  parameter int N_FEAT    = DEF_N_FEAT,
  parameter int FEAT_W    = DEF_FEAT_W,
  parameter int CLASS_W   = DEF_CLASS_W,
  parameter int N_NODES   = DEF_N_NODES,
  parameter int MAX_DEPTH = DEF_MAX_DEPTH
) (
  input  logic clk,
  input  logic rst,
  dtree_seq_classifier_if.slave bus
`ifdef DTREE_STATS_EN
  ,
  output logic [31:0] stat_done,
  output logic [31:0] stat_err
`endif
);
  localparam int FIDX_W    = idx_w(N_FEAT);
  localparam int NODE_AW   = idx_w(N_NODES);
  localparam int NODE_W    = node_w(N_FEAT, FEAT_W, N_NODES, CLASS_W);
  localparam int DEPTH_W   = idx_w(MAX_DEPTH + 1);
  localparam int RIGHT_LSB = right_lsb(CLASS_W);
  localparam int LEFT_LSB  = left_lsb(CLASS_W, N_NODES);
  localparam int THR_LSB   = thr_lsb(CLASS_W, N_NODES);
  localparam int FIDX_LSB  = fidx_lsb(CLASS_W, N_NODES, FEAT_W);
  localparam int LEAF_BIT  = leaf_bit(N_FEAT, FEAT_W, N_NODES, CLASS_W);

  localparam logic [FIDX_W:0]  FEAT_LIM  = (FIDX_W+1)'(N_FEAT);
  localparam logic [NODE_AW:0] NODE_LIM  = (NODE_AW+1)'(N_NODES);
  localparam logic [DEPTH_W-1:0] DEPTH_LIM = DEPTH_W'(MAX_DEPTH);

  state_e                   state_q, state_d;
  logic [NODE_AW-1:0]       ptr_q, ptr_d;
  logic [DEPTH_W-1:0]       depth_q, depth_d;
  logic [N_FEAT*FEAT_W-1:0] x_q, x_d;
  logic [CLASS_W-1:0]       class_q, class_d;
  logic                     err_q, err_d;

  logic [NODE_W-1:0]  node;
  logic               node_leaf;
  logic [FIDX_W-1:0]  node_fidx;
  logic [FEAT_W-1:0]  node_thr;
  logic [NODE_AW-1:0] node_left;
  logic [NODE_AW-1:0] node_right;
  logic [CLASS_W-1:0] node_class;
  logic [FEAT_W-1:0]  feat_sel;
  logic [NODE_AW-1:0] child;
  logic               cfg_wr;

  assign cfg_wr = bus.cfg_we && (state_q == ST_IDLE);

  dtree_node_mem #(
    .N_NODES (N_NODES),
    .NODE_W  (NODE_W),
    .AW      (NODE_AW)
  ) u_node_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (cfg_wr),
    .waddr (bus.cfg_addr),
    .wdata (bus.cfg_data),
    .raddr (ptr_q),
    .rdata (node)
  );

  assign node_leaf  = node[LEAF_BIT];
  assign node_fidx  = node[FIDX_LSB +: FIDX_W];
  assign node_thr   = node[THR_LSB +: FEAT_W];
  assign node_left  = node[LEFT_LSB +: NODE_AW];
  assign node_right = node[RIGHT_LSB +: NODE_AW];
  assign node_class = node[0 +: CLASS_W];

  always_comb begin
    feat_sel = '0;
    for (int i = 0; i < N_FEAT; i++) begin
      if (node_fidx == FIDX_W'(i)) begin
        feat_sel = x_q[i*FEAT_W +: FEAT_W];
      end
    end
  end

  assign child = (feat_sel <= node_thr) ? node_left : node_right;

  // Abort checks are ordered leaf -> feature index -> depth -> child range.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    depth_d = depth_q;
    x_d     = x_q;
    class_d = class_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          x_d     = bus.in_x;
          ptr_d   = '0;
          depth_d = '0;
          state_d = ST_WALK;
        end
      end
      ST_WALK: begin
        if (node_leaf) begin
          class_d = node_class;
          err_d   = 1'b0;
          state_d = ST_DONE;
        end else if (({1'b0, node_fidx} >= FEAT_LIM) || (depth_q == DEPTH_LIM) ||
                     ({1'b0, child} >= NODE_LIM)) begin
          class_d = '0;
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          ptr_d   = child;
          depth_d = depth_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      depth_q <= '0;
      x_q     <= '0;
      class_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      depth_q <= depth_d;
      x_q     <= x_d;
      class_q <= class_d;
      err_q   <= err_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.out_class = class_q;
  assign bus.out_err   = err_q;
  assign bus.cfg_busy  = (state_q != ST_IDLE);

`ifdef DTREE_STATS_EN
  logic [31:0] stat_done_q, stat_done_d;
  logic [31:0] stat_err_q, stat_err_d;

  always_comb begin
    stat_done_d = stat_done_q;
    stat_err_d  = stat_err_q;
    if ((state_q == ST_DONE) && bus.out_ready) begin
      if (stat_done_q != 32'hFFFF_FFFF) begin
        stat_done_d = stat_done_q + 32'd1;
      end
      if (err_q && (stat_err_q != 32'hFFFF_FFFF)) begin
        stat_err_d = stat_err_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_done_q <= '0;
      stat_err_q  <= '0;
    end else begin
      stat_done_q <= stat_done_d;
      stat_err_q  <= stat_err_d;
    end
  end

  assign stat_done = stat_done_q;
  assign stat_err  = stat_err_q;
`endif

endmodule

// File: tb/tb_dtree_seq_classifier.sv
// Directed self-checking bench for dtree_seq_classifier (optionally with DTREE_STATS_EN).
module tb_dtree_seq_classifier;
  localparam int N_FEAT = 9;
  localparam int FEAT_W = 8;
  localparam int XW     = N_FEAT * FEAT_W;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  dtree_seq_classifier_if #(
    .N_FEAT(9), .FEAT_W(8), .CLASS_W(2), .N_NODES(31)
  ) bus ();

`ifdef DTREE_STATS_EN
  logic [31:0] stat_done;
  logic [31:0] stat_err;
`endif

  dtree_seq_classifier #(
    .N_FEAT(9), .FEAT_W(8), .CLASS_W(2), .N_NODES(31), .MAX_DEPTH(5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef DTREE_STATS_EN
    ,
    .stat_done (stat_done),
    .stat_err  (stat_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [24:0] mk_node(input logic leaf, input logic [3:0] fidx,
                                          input logic [7:0] thr, input logic [4:0] l,
                                          input logic [4:0] r, input logic [1:0] cls);
    return {leaf, fidx, thr, l, r, cls};
  endfunction

  function automatic logic [XW-1:0] with_feat(input logic [XW-1:0] base, input int idx,
                                              input logic [7:0] v);
    logic [XW-1:0] x;
    x = base;
    x[idx*FEAT_W +: FEAT_W] = v;
    return x;
  endfunction

  task automatic cfg_write(input logic [4:0] addr, input logic [24:0] data);
    int guard;
    guard = 0;
    @(negedge clk);
    while (bus.cfg_busy !== 1'b0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = addr;
    bus.cfg_data = data;
    @(negedge clk);
    bus.cfg_we   = 1'b0;
  endtask

  // Latency is counted in clocks from the accepting edge; -1 means no result arrived.
  task automatic run_vec(input logic [XW-1:0] x, output int lat,
                         output logic [1:0] cls, output logic err);
    int guard;
    guard = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_x     = x;
    while (bus.in_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_x     = ~x;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid === 1'b1) begin
        lat = i;
        break;
      end
    end
    cls = bus.out_class;
    err = bus.out_err;
  endtask

  task automatic load_branch_tree();
    cfg_write(5'd0, mk_node(1'b0, 4'd2, 8'h80, 5'd1, 5'd2, 2'd0));
    cfg_write(5'd1, mk_node(1'b1, 4'd0, 8'h00, 5'd0, 5'd0, 2'd1));
    cfg_write(5'd2, mk_node(1'b1, 4'd0, 8'h00, 5'd0, 5'd0, 2'd2));
  endtask

  task automatic test_reset();
    int lat;
    logic [1:0] cls;
    logic err;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks += 5;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_in_ready got %b want 1", bus.in_ready); end
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_valid got %b want 0", bus.out_valid); end
    if (bus.out_class !== 2'd0) begin n_fail++; $display("[TB] FAIL reset_out_class got %0d want 0", bus.out_class); end
    if (bus.out_err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_err got %b want 0", bus.out_err); end
    if (bus.cfg_busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_cfg_busy got %b want 0", bus.cfg_busy); end
    rst = 1'b0;
    run_vec('0, lat, cls, err);
    n_checks += 3;
    if (lat != 1) begin n_fail++; $display("[TB] FAIL unconfig_latency got %0d want 1", lat); end
    if (cls !== 2'd0) begin n_fail++; $display("[TB] FAIL unconfig_class got %0d want 0", cls); end
    if (err !== 1'b0) begin n_fail++; $display("[TB] FAIL unconfig_err got %b want 0", err); end
  endtask

  task automatic test_branch();
    logic [7:0] xv [4];
    logic [1:0] want [4];
    int lat;
    logic [1:0] cls;
    logic err;
    xv   = '{8'h80, 8'h81, 8'h00, 8'hFF};
    want = '{2'd1, 2'd2, 2'd1, 2'd2};
    load_branch_tree();
    for (int k = 0; k < 4; k++) begin
      run_vec(with_feat({XW{1'b1}} ^ XW'(72'h5A), 2, xv[k]), lat, cls, err);
      n_checks += 3;
      if (lat != 2) begin n_fail++; $display("[TB] FAIL branch_latency x2=%0h got %0d want 2", xv[k], lat); end
      if (cls !== want[k]) begin n_fail++; $display("[TB] FAIL branch_class x2=%0h got %0d want %0d", xv[k], cls, want[k]); end
      if (err !== 1'b0) begin n_fail++; $display("[TB] FAIL branch_err x2=%0h got %b want 0", xv[k], err); end
    end
    cfg_write(5'd0, mk_node(1'b0, 4'd8, 8'h10, 5'd1, 5'd2, 2'd0));
    run_vec(with_feat('0, 8, 8'h11), lat, cls, err);
    n_checks += 2;
    if (cls !== 2'd2) begin n_fail++; $display("[TB] FAIL last_feature_class got %0d want 2", cls); end
    if (err !== 1'b0) begin n_fail++; $display("[TB] FAIL last_feature_err got %b want 0", err); end
  endtask

  task automatic test_errors();
    int lat;
    logic [1:0] cls;
    logic err;
    for (int i = 0; i < 5; i++) begin
      cfg_write(5'(i), mk_node(1'b0, 4'd0, 8'hFF, 5'(i + 1), 5'(i + 1), 2'd3));
    end
    cfg_write(5'd5, mk_node(1'b1, 4'd0, 8'h00, 5'd0, 5'd0, 2'd3));
    run_vec(with_feat('0, 0, 8'h42), lat, cls, err);
    n_checks += 3;
    if (lat != 6) begin n_fail++; $display("[TB] FAIL max_depth_leaf_latency got %0d want 6", lat); end
    if (cls !== 2'd3) begin n_fail++; $display("[TB] FAIL max_depth_leaf_class got %0d want 3", cls); end
    if (err !== 1'b0) begin n_fail++; $display("[TB] FAIL max_depth_leaf_err got %b want 0", err); end
    cfg_write(5'd5, mk_node(1'b0, 4'd0, 8'hFF, 5'd6, 5'd6, 2'd3));
    cfg_write(5'd6, mk_node(1'b1, 4'd0, 8'h00, 5'd0, 5'd0, 2'd1));
    run_vec(with_feat('0, 0, 8'h42), lat, cls, err);
    n_checks += 3;
    if (lat != 6) begin n_fail++; $display("[TB] FAIL depth_overflow_latency got %0d want 6", lat); end
    if (cls !== 2'd0) begin n_fail++; $display("[TB] FAIL depth_overflow_class got %0d want 0", cls); end
    if (err !== 1'b1) begin n_fail++; $display("[TB] FAIL depth_overflow_err got %b want 1", err); end
    cfg_write(5'd0, mk_node(1'b0, 4'd9, 8'hFF, 5'd1, 5'd1, 2'd3));
    run_vec('0, lat, cls, err);
    n_checks += 3;
    if (lat != 1) begin n_fail++; $display("[TB] FAIL bad_fidx_latency got %0d want 1", lat); end
    if (cls !== 2'd0) begin n_fail++; $display("[TB] FAIL bad_fidx_class got %0d want 0", cls); end
    if (err !== 1'b1) begin n_fail++; $display("[TB] FAIL bad_fidx_err got %b want 1", err); end
    cfg_write(5'd0, mk_node(1'b0, 4'd0, 8'hFF, 5'd31, 5'd1, 2'd3));
    run_vec('0, lat, cls, err);
    n_checks += 2;
    if (cls !== 2'd0) begin n_fail++; $display("[TB] FAIL bad_child_class got %0d want 0", cls); end
    if (err !== 1'b1) begin n_fail++; $display("[TB] FAIL bad_child_err got %b want 1", err); end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [1:0] cls;
    logic err;
    load_branch_tree();
    bus.out_ready = 1'b0;
    run_vec(with_feat('0, 2, 8'h81), lat, cls, err);
    n_checks += 1;
    if (cls !== 2'd2) begin n_fail++; $display("[TB] FAIL hold_first_class got %0d want 2", cls); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      n_checks += 3;
      if (bus.out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL hold_out_valid cyc %0d got %b want 1", i, bus.out_valid); end
      if (bus.out_class !== 2'd2) begin n_fail++; $display("[TB] FAIL hold_out_class cyc %0d got %0d want 2", i, bus.out_class); end
      if (bus.in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL hold_in_ready cyc %0d got %b want 0", i, bus.in_ready); end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    n_checks += 2;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL release_in_ready got %b want 1", bus.in_ready); end
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL release_out_valid got %b want 0", bus.out_valid); end
  endtask

  task automatic test_cfg_during_walk();
    int lat;
    logic [1:0] cls;
    logic err;
    int guard;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_x     = with_feat('0, 2, 8'h80);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = 5'd1;
    bus.cfg_data = mk_node(1'b1, 4'd0, 8'h00, 5'd0, 5'd0, 2'd3);
    n_checks += 1;
    if (bus.cfg_busy !== 1'b1) begin n_fail++; $display("[TB] FAIL walk_cfg_busy got %b want 1", bus.cfg_busy); end
    @(posedge clk);
    #1;
    bus.cfg_we = 1'b0;
    guard = 0;
    while (bus.out_valid !== 1'b1 && guard < 40) begin
      @(posedge clk);
      #1;
      guard++;
    end
    n_checks += 1;
    if (bus.out_class !== 2'd1) begin n_fail++; $display("[TB] FAIL walk_cfg_result got %0d want 1", bus.out_class); end
    run_vec(with_feat('0, 2, 8'h80), lat, cls, err);
    n_checks += 1;
    if (cls !== 2'd1) begin n_fail++; $display("[TB] FAIL walk_cfg_readback got %0d want 1", cls); end
  endtask

  task automatic test_reset_mid_walk();
    int lat;
    logic [1:0] cls;
    logic err;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_x     = with_feat('0, 2, 8'h81);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    n_checks += 3;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL midreset_out_valid got %b want 0", bus.out_valid); end
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL midreset_in_ready got %b want 1", bus.in_ready); end
    if (bus.cfg_busy !== 1'b0) begin n_fail++; $display("[TB] FAIL midreset_cfg_busy got %b want 0", bus.cfg_busy); end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      n_checks += 1;
      if (bus.out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL post_reset_out_valid got %b want 0", bus.out_valid); end
    end
    run_vec(with_feat('0, 2, 8'h81), lat, cls, err);
    n_checks += 2;
    if (lat != 1) begin n_fail++; $display("[TB] FAIL table_reset_latency got %0d want 1", lat); end
    if (cls !== 2'd0) begin n_fail++; $display("[TB] FAIL table_reset_class got %0d want 0", cls); end
  endtask

`ifdef DTREE_STATS_EN
  task automatic test_stats();
    int lat;
    logic [1:0] cls;
    logic err;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks += 1;
    if (stat_done !== 32'd0) begin n_fail++; $display("[TB] FAIL stat_reset got %0d want 0", stat_done); end
    repeat (3) run_vec('0, lat, cls, err);
    cfg_write(5'd0, mk_node(1'b0, 4'd15, 8'h00, 5'd1, 5'd1, 2'd0));
    run_vec('0, lat, cls, err);
    @(posedge clk);
    #1;
    n_checks += 2;
    if (stat_done !== 32'd4) begin n_fail++; $display("[TB] FAIL stat_done got %0d want 4", stat_done); end
    if (stat_err !== 32'd1) begin n_fail++; $display("[TB] FAIL stat_err got %0d want 1", stat_err); end
  endtask
`endif

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_x      = '0;
    bus.out_ready = 1'b1;
    bus.cfg_we    = 1'b0;
    bus.cfg_addr  = '0;
    bus.cfg_data  = '0;
    $display("[TB] starting dtree_seq_classifier bench");
    test_reset();
    test_branch();
    test_errors();
    test_backpressure();
    test_cfg_during_walk();
    test_reset_mid_walk();
`ifdef DTREE_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
